// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage with deferred redirect and IF/ID register
//
// Holds the PC, steps it by 4, redirects it to branch/jump targets, and loads
// the IF/ID pipeline register. A redirect that arrives while the PC is stalled
// is latched and applied on the first cycle the PC may move again.
//
// Ports:
//   Clk, Reset        rising-edge clock, synchronous active-high reset
//   PCWrite           PC may update this cycle
//   IFIDWrite         IF/ID may load this cycle
//   IFIDFlush         IF/ID loads a bubble this cycle (beats IFIDWrite)
//   BranchTaken       ID resolved a taken branch/jump; BranchTarget is valid
//   BranchTarget      redirect address (low two bits ignored)
//   Instruction       instruction-memory read data for PCOut
//   PCOut             current PC
//   IFIDInstruction   registered instruction
//   IFIDPCPlus4       registered PC+4 of that instruction
//   IFIDValid         0 when IF/ID holds a bubble
//   RedirectPending   a redirect is latched and waiting for PCWrite
//   StallCycles       saturating count of IF/ID stall cycles
//   FlushCount        saturating count of IF/ID flush cycles

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PCWrite,
    input  logic             IFIDWrite,
    input  logic             IFIDFlush,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchTarget,
    input  logic [31:0]      Instruction,
    output logic [31:0]      PCOut,
    output logic [31:0]      IFIDInstruction,
    output logic [31:0]      IFIDPCPlus4,
    output logic             IFIDValid,
    output logic             RedirectPending,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    logic        state;
    logic        next_state;
    logic [31:0] pending_target;
    logic [31:0] next_target;
    logic [31:0] next_pc;
    logic [31:0] aligned_target;
    logic [31:0] pc_plus4;

    // Targets are word addresses; the byte-offset bits are dropped everywhere.
    assign aligned_target  = {BranchTarget[31:2], 2'b00};
    assign pc_plus4        = PCOut + 32'd4;
    assign RedirectPending = (state == ST_HOLD);

    always_comb begin
        next_state  = state;
        next_target = pending_target;
        next_pc     = PCOut;
        if (state == ST_RUN) begin
            if (BranchTaken) begin
                if (PCWrite) begin
                    next_pc = aligned_target;
                end else begin
                    next_target = aligned_target;
                    next_state  = ST_HOLD;
                end
            end else if (PCWrite) begin
                next_pc = pc_plus4;
            end
        end else begin
            // A fresh redirect while held supersedes the latched one.
            if (BranchTaken) begin
                next_target = aligned_target;
            end
            if (PCWrite) begin
                next_pc    = BranchTaken ? aligned_target : pending_target;
                next_state = ST_RUN;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= ST_RUN;
            pending_target <= 32'h0000_0000;
            PCOut          <= RESET_PC;
        end else begin
            state          <= next_state;
            pending_target <= next_target;
            PCOut          <= next_pc;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            IFIDInstruction <= 32'h0000_0000;
            IFIDPCPlus4     <= 32'h0000_0000;
            IFIDValid       <= 1'b0;
        end else if (IFIDFlush) begin
            // Bubble is an all-zero word, i.e. sll $0,$0,0.
            IFIDInstruction <= 32'h0000_0000;
            IFIDPCPlus4     <= 32'h0000_0000;
            IFIDValid       <= 1'b0;
        end else if (IFIDWrite) begin
            IFIDInstruction <= Instruction;
            IFIDPCPlus4     <= pc_plus4;
            IFIDValid       <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (!IFIDWrite && !IFIDFlush && (StallCycles != '1)) begin
                StallCycles <= StallCycles + 1'b1;
            end
            if (IFIDFlush && (FlushCount != '1)) begin
                FlushCount <= FlushCount + 1'b1;
            end
        end
    end

endmodule
